inv_cast: RTL and testbench

INV_CAST -- requirements
Module: inv_cast

---
 rtl/inv_cast.sv | 208 ++++++++++++++++++++
 tb/tb_inv_cast.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_cast.sv
// inv_cast: rebuilds IEEE-754 doubles from block-floating-point data.
// Each block is one shared exponent (emax) followed by BLOCK_LEN
// two's-complement fixed-point coefficients. Each coefficient is turned into
// sign / exponent / fraction and registered into a single output stage.
module inv_cast #(
  parameter int BLOCK_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] s_ex_data,
  input  logic        s_ex_valid,
  output logic        s_ex_ready,
  input  logic [63:0] s_int_data,
  input  logic        s_int_valid,
  output logic        s_int_ready,
  output logic [51:0] m_fp_data_frac,
  output logic [10:0] m_fp_data_expo,
  output logic        m_fp_data_sign,
  output logic        m_fp_valid,
  input  logic        m_fp_ready
);

  // The coefficient counter only has to reach BLOCK_LEN-1.
  localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_LEN - 1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Returns the bit position of the most significant one (0 when v is zero).
  function automatic logic [5:0] lead_one(input logic [63:0] v);
    logic [5:0] pos;
    pos = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) begin
        pos = 6'(i);
      end
    end
    return pos;
  endfunction

  // Converts one fixed-point coefficient to {sign, expo[10:0], frac[51:0]}.
  // The exponent is worked out in 13-bit signed arithmetic so that both
  // underflow (<= 0) and overflow (>= 2047) can be seen before saturating.
  // The fraction is truncated; most negative input -2^63 has magnitude 2^63.
  function automatic logic [63:0] to_double(input logic [10:0] emax,
                                            input logic [63:0] x);
    logic               sign;
    logic [63:0]        mag;
    logic [5:0]         p;
    logic signed [12:0] e;
    logic [63:0]        sh;
    logic [51:0]        frac;
    logic [63:0]        res;
    sign = x[63];
    mag  = sign ? (~x + 64'd1) : x;
    p    = lead_one(mag);
    e    = $signed({2'b00, emax}) + $signed({7'b0000000, p}) - 13'sd62;
    // Put the leading one at bit 63; the 52 bits below it are the fraction.
    sh   = mag << (6'd63 - p);
    frac = 52'(sh >> 6'd11);
    if (mag == 64'd0) begin
      res = 64'd0;
    end else if (e <= 13'sd0) begin
      res = {sign, 11'd0, 52'd0};
    end else if (e >= 13'sd2047) begin
      res = {sign, 11'h7FF, 52'd0};
    end else begin
      res = {sign, e[10:0], frac};
    end
    return res;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [10:0]    emax_q, emax_d;
  logic           valid_q, valid_d;
  logic           sign_q, sign_d;
  logic [10:0]    expo_q, expo_d;
  logic [51:0]    frac_q, frac_d;

  logic           ex_ready_s;
  logic           int_ready_s;
  logic           last_beat_s;
  logic           ex_xfer_s;
  logic           int_xfer_s;
  logic [63:0]    conv_s;

  assign last_beat_s = (count_q == LAST_CNT);

  // Handshake readiness: exponent in IDLE, coefficients in RUN while the
  // output stage can take a value; the next exponent is accepted only
  // alongside the last coefficient of the block.
  always_comb begin
    ex_ready_s  = 1'b0;
    int_ready_s = 1'b0;
    case (state_q)
      IDLE: begin
        ex_ready_s  = 1'b1;
        int_ready_s = 1'b0;
      end
      RUN: begin
        int_ready_s = !valid_q || m_fp_ready;
        ex_ready_s  = int_ready_s && s_int_valid && last_beat_s;
      end
      default: begin
        ex_ready_s  = 1'b0;
        int_ready_s = 1'b0;
      end
    endcase
  end

  // Nobody may transfer while reset is asserted.
  assign s_ex_ready  = ex_ready_s && !reset;
  assign s_int_ready = int_ready_s && !reset;
  assign ex_xfer_s   = s_ex_valid && s_ex_ready;
  assign int_xfer_s  = s_int_valid && s_int_ready;

  // Block sequencing: latch emax, count coefficients, chain blocks seamlessly.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    emax_d  = emax_q;
    case (state_q)
      IDLE: begin
        if (ex_xfer_s) begin
          emax_d  = s_ex_data;
          count_d = ZERO_CNT;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (int_xfer_s) begin
          if (last_beat_s) begin
            count_d = ZERO_CNT;
            if (ex_xfer_s) begin
              emax_d  = s_ex_data;
              state_d = RUN;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + ONE_CNT;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = ZERO_CNT;
      end
    endcase
  end

  // The conversion uses the emax of the block the coefficient belongs to.
  assign conv_s = to_double(emax_q, s_int_data);

  // Output stage: load on a coefficient transfer, drain on m_fp_ready,
  // otherwise hold every field steady.
  always_comb begin
    valid_d = valid_q;
    sign_d  = sign_q;
    expo_d  = expo_q;
    frac_d  = frac_q;
    if (int_xfer_s) begin
      valid_d                  = 1'b1;
      {sign_d, expo_d, frac_d} = conv_s;
    end else if (m_fp_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, counter, emax and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= ZERO_CNT;
      emax_q  <= 11'd0;
      valid_q <= 1'b0;
      sign_q  <= 1'b0;
      expo_q  <= 11'd0;
      frac_q  <= 52'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      emax_q  <= emax_d;
      valid_q <= valid_d;
      sign_q  <= sign_d;
      expo_q  <= expo_d;
      frac_q  <= frac_d;
    end
  end

  assign m_fp_valid     = valid_q;
  assign m_fp_data_sign = sign_q;
  assign m_fp_data_expo = expo_q;
  assign m_fp_data_frac = frac_q;

endmodule

// File: tb/tb_inv_cast.sv
// Directed, table-driven bench for inv_cast (BLOCK_LEN = 4).
module tb_inv_cast;

  logic        clk;
  logic        reset;
  logic [10:0] s_ex_data;
  logic        s_ex_valid;
  logic        s_ex_ready;
  logic [63:0] s_int_data;
  logic        s_int_valid;
  logic        s_int_ready;
  logic [51:0] m_fp_data_frac;
  logic [10:0] m_fp_data_expo;
  logic        m_fp_data_sign;
  logic        m_fp_valid;
  logic        m_fp_ready;

  int errors = 0;
  int checks = 0;

  inv_cast #(.BLOCK_LEN(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_ex_data      (s_ex_data),
    .s_ex_valid     (s_ex_valid),
    .s_ex_ready     (s_ex_ready),
    .s_int_data     (s_int_data),
    .s_int_valid    (s_int_valid),
    .s_int_ready    (s_int_ready),
    .m_fp_data_frac (m_fp_data_frac),
    .m_fp_data_expo (m_fp_data_expo),
    .m_fp_data_sign (m_fp_data_sign),
    .m_fp_valid     (m_fp_valid),
    .m_fp_ready     (m_fp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] emax;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic logic [63:0] mk(input logic s, input logic [10:0] e, input logic [51:0] f);
    return {s, e, f};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [63:0] exp);
    chk({name, " valid"}, {63'd0, m_fp_valid}, 64'd1);
    chk({name, " data"}, {m_fp_data_sign, m_fp_data_expo, m_fp_data_frac}, exp);
  endtask

  // One coefficient with the output stage free: check readies, then result.
  task automatic beat(input string name, input logic [63:0] d, input logic exp_exr, input logic [63:0] exp);
    s_int_valid = 1'b1;
    s_int_data  = d;
    #1;
    chk({name, " int_ready"}, {63'd0, s_int_ready}, 64'd1);
    chk({name, " ex_ready"}, {63'd0, s_ex_ready}, {63'd0, exp_exr});
    tick();
    chk_out(name, exp);
  endtask

  initial begin
    // block 0: emax 1024
    vecs[0]  = '{11'd1024, 64'h4000_0000_0000_0000, mk(1'b0, 11'd1024, 52'd0)};
    vecs[1]  = '{11'd1024, 64'hC000_0000_0000_0000, mk(1'b1, 11'd1024, 52'd0)};
    vecs[2]  = '{11'd1024, 64'h0000_0000_0000_0000, mk(1'b0, 11'd0,    52'd0)};
    vecs[3]  = '{11'd1024, 64'h2000_0000_0000_0000, mk(1'b0, 11'd1023, 52'd0)};
    // block 1: emax 1024
    vecs[4]  = '{11'd1024, 64'h3000_0000_0000_0000, mk(1'b0, 11'd1023, 52'h8_0000_0000_0000)};
    vecs[5]  = '{11'd1024, 64'h8000_0000_0000_0000, mk(1'b1, 11'd1025, 52'd0)};
    vecs[6]  = '{11'd1024, 64'h7FFF_FFFF_FFFF_FFFF, mk(1'b0, 11'd1024, 52'hF_FFFF_FFFF_FFFF)};
    vecs[7]  = '{11'd1024, 64'hFFFF_FFFF_FFFF_FFFF, mk(1'b1, 11'd962,  52'd0)};
    // block 2: emax 2047, overflow to infinity
    vecs[8]  = '{11'd2047, 64'h7FFF_FFFF_FFFF_FFFF, mk(1'b0, 11'd2047, 52'd0)};
    vecs[9]  = '{11'd2047, 64'h8000_0000_0000_0000, mk(1'b1, 11'd2047, 52'd0)};
    vecs[10] = '{11'd2047, 64'h0000_0000_0000_0001, mk(1'b0, 11'd1985, 52'd0)};
    vecs[11] = '{11'd2047, 64'hFFFF_FFFF_FFFF_FFFB, mk(1'b1, 11'd1987, 52'h4_0000_0000_0000)};
    // block 3: emax 10, underflow to signed zero
    vecs[12] = '{11'd10,   64'h0000_0000_0000_0001, mk(1'b0, 11'd0,    52'd0)};
    vecs[13] = '{11'd10,   64'hFFFF_FFFF_FFFF_FFFF, mk(1'b1, 11'd0,    52'd0)};
    vecs[14] = '{11'd10,   64'h4000_0000_0000_0000, mk(1'b0, 11'd10,   52'd0)};
    vecs[15] = '{11'd10,   64'h0008_0000_0000_0000, mk(1'b0, 11'd0,    52'd0)};
    // block 4: emax 2040, truncation and short magnitudes
    vecs[16] = '{11'd2040, 64'h7FFF_FFFF_FFFF_FFFF, mk(1'b0, 11'd2040, 52'hF_FFFF_FFFF_FFFF)};
    vecs[17] = '{11'd2040, 64'h2000_0000_0000_0000, mk(1'b0, 11'd2039, 52'd0)};
    vecs[18] = '{11'd2040, 64'h4000_0000_0000_0400, mk(1'b0, 11'd2040, 52'h0_0000_0000_0001)};
    vecs[19] = '{11'd2040, 64'h0000_0000_0000_0C00, mk(1'b0, 11'd1989, 52'h8_0000_0000_0000)};

    reset       = 1'b1;
    s_ex_data   = 11'd0;
    s_ex_valid  = 1'b0;
    s_int_data  = 64'd0;
    s_int_valid = 1'b0;
    m_fp_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst valid", {63'd0, m_fp_valid}, 64'd0);
    chk("rst ex_ready", {63'd0, s_ex_ready}, 64'd0);
    chk("rst int_ready", {63'd0, s_int_ready}, 64'd0);
    chk("rst data", {m_fp_data_sign, m_fp_data_expo, m_fp_data_frac}, 64'd0);
    reset = 1'b0;
    #1;
    chk("idle ex_ready", {63'd0, s_ex_ready}, 64'd1);
    chk("idle int_ready", {63'd0, s_int_ready}, 64'd0);

    // Coefficients are ignored in IDLE
    s_int_valid = 1'b1;
    s_int_data  = 64'd5;
    #1;
    chk("idle int ignored ready", {63'd0, s_int_ready}, 64'd0);
    tick();
    chk("idle int ignored valid", {63'd0, m_fp_valid}, 64'd0);
    s_int_valid = 1'b0;

    // Table: five blocks back to back, next emax always presented early
    s_ex_valid = 1'b1;
    s_ex_data  = vecs[0].emax;
    #1;
    chk("tbl start ex_ready", {63'd0, s_ex_ready}, 64'd1);
    tick();
    for (int i = 0; i < NV; i++) begin
      if (i / 4 < NV / 4 - 1) begin
        s_ex_valid = 1'b1;
        s_ex_data  = vecs[(i / 4 + 1) * 4].emax;
      end else begin
        s_ex_valid = 1'b0;
      end
      beat($sformatf("tbl[%0d]", i), vecs[i].din, (i % 4) == 3, vecs[i].exp);
    end
    s_int_valid = 1'b0;
    s_ex_valid  = 1'b0;
    #1;
    chk("tbl end idle ex_ready", {63'd0, s_ex_ready}, 64'd1);
    tick();
    chk("tbl end drained", {63'd0, m_fp_valid}, 64'd0);

    // Backpressure: m_fp_ready low 3 cycles mid-block
    s_ex_valid = 1'b1;
    s_ex_data  = 11'd1024;
    tick();
    s_ex_valid = 1'b0;
    beat("bp A", 64'h4000_0000_0000_0000, 1'b0, mk(1'b0, 11'd1024, 52'd0));
    beat("bp B", 64'hC000_0000_0000_0000, 1'b0, mk(1'b1, 11'd1024, 52'd0));
    m_fp_ready = 1'b0;
    s_int_data = 64'h3000_0000_0000_0000;
    #1;
    chk("bp stall int_ready", {63'd0, s_int_ready}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("bp hold[%0d]", k), mk(1'b1, 11'd1024, 52'd0));
      chk($sformatf("bp hold[%0d] int_ready", k), {63'd0, s_int_ready}, 64'd0);
    end
    m_fp_ready = 1'b1;
    #1;
    chk("bp resume int_ready", {63'd0, s_int_ready}, 64'd1);
    tick();
    chk_out("bp C", mk(1'b0, 11'd1023, 52'h8_0000_0000_0000));
    beat("bp D", 64'h2000_0000_0000_0000, 1'b1, mk(1'b0, 11'd1023, 52'd0));
    s_int_valid = 1'b0;
    tick();
    chk("bp no dup", {63'd0, m_fp_valid}, 64'd0);
    chk("bp idle ex_ready", {63'd0, s_ex_ready}, 64'd1);

    // Reset after 2 of 4 coefficients
    s_ex_valid = 1'b1;
    s_ex_data  = 11'd1024;
    tick();
    s_ex_valid = 1'b0;
    beat("rs A", 64'h4000_0000_0000_0000, 1'b0, mk(1'b0, 11'd1024, 52'd0));
    beat("rs B", 64'hC000_0000_0000_0000, 1'b0, mk(1'b1, 11'd1024, 52'd0));
    s_int_data = 64'h3000_0000_0000_0000;
    reset      = 1'b1;
    #1;
    chk("rs valid", {63'd0, m_fp_valid}, 64'd0);
    chk("rs data", {m_fp_data_sign, m_fp_data_expo, m_fp_data_frac}, 64'd0);
    chk("rs ex_ready", {63'd0, s_ex_ready}, 64'd0);
    chk("rs int_ready", {63'd0, s_int_ready}, 64'd0);
    tick();
    s_int_valid = 1'b0;
    reset       = 1'b0;
    #1;
    chk("rs release ex_ready", {63'd0, s_ex_ready}, 64'd1);
    chk("rs release int_ready", {63'd0, s_int_ready}, 64'd0);
    chk("rs release valid", {63'd0, m_fp_valid}, 64'd0);
    s_ex_valid = 1'b1;
    s_ex_data  = 11'd10;
    tick();
    s_ex_valid = 1'b0;
    beat("rs n0", 64'h4000_0000_0000_0000, 1'b0, mk(1'b0, 11'd10, 52'd0));
    beat("rs n1", 64'hC000_0000_0000_0000, 1'b0, mk(1'b1, 11'd10, 52'd0));
    beat("rs n2", 64'h2000_0000_0000_0000, 1'b0, mk(1'b0, 11'd9, 52'd0));
    beat("rs n3", 64'h3000_0000_0000_0000, 1'b1, mk(1'b0, 11'd9, 52'h8_0000_0000_0000));
    s_int_valid = 1'b0;
    #1;
    chk("rs end idle ex_ready", {63'd0, s_ex_ready}, 64'd1);
    tick();
    chk("rs end drained", {63'd0, m_fp_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
